// File: rtl/lut_truth_table_checker.sv
// ---------------------------------------------------------------------------
// lut_truth_table_checker
//
// On-fabric self-checking harness for small LUT install tests. It sweeps
// every input vector of the LUT under test and holds each vector for a settle
// window. At the end of the window it samples the LUT output and compares it
// with TRUTH_TABLE. It reports pass/fail, the number of mismatching vectors
// and the lowest failing vector.
//
// Parameters:
//   N_INPUTS      number of LUT inputs driven (1..6)
//   TRUTH_TABLE   expected output, bit i is the value for lut_in == i
//   SETTLE_CYCLES cycles each vector is held before the sample cycle (>=1)
//
// Ports:
//   clk              rising-edge clock for all state
//   rst_n            asynchronous active-low reset
//   start            one-cycle pulse, starts a sweep from IDLE or DONE
//   lut_in           registered vector driven to the LUT inputs
//   lut_out          LUT output (combinational, possibly unsettled)
//   busy             sweep in progress
//   done             sweep finished, held until the next start
//   pass             valid with done, 1 when no vector mismatched
//   err_count        number of mismatching vectors (saturating)
//   first_fail_valid at least one mismatch recorded
//   first_fail_vec   lowest vector index that mismatched
//
// Optional build macro:
//   LUT_CHECK_SYNC_EN  passes lut_out through a 2-flop synchroniser. The
//                      settle window is then stretched by two cycles, so the
//                      sampled bit belongs to the vector currently driven.
// ---------------------------------------------------------------------------
module lut_truth_table_checker #(
  parameter int                         N_INPUTS      = 2,
  parameter logic [(2**N_INPUTS)-1:0]   TRUTH_TABLE   = 4'b1010,
  parameter int                         SETTLE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_INPUTS-1:0]  lut_in,
  input  logic                 lut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_INPUTS:0]    err_count,
  output logic                 first_fail_valid,
  output logic [N_INPUTS-1:0]  first_fail_vec
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 3);
  localparam int N_VEC = 2**N_INPUTS;

  localparam logic [N_INPUTS-1:0] LAST_VEC = N_INPUTS'(N_VEC - 1);
  localparam logic [N_INPUTS-1:0] IDX_ZERO = {N_INPUTS{1'b0}};
  localparam logic [N_INPUTS-1:0] IDX_ONE  = N_INPUTS'(1);
  localparam logic [N_INPUTS:0]   ERR_ZERO = {(N_INPUTS+1){1'b0}};
  localparam logic [N_INPUTS:0]   ERR_ONE  = (N_INPUTS+1)'(1);
  localparam logic [N_INPUTS:0]   ERR_MAX  = (N_INPUTS+1)'(N_VEC);
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

`ifdef LUT_CHECK_SYNC_EN
  // Two extra settle cycles cover the synchroniser latency.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES + 1);
`else
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [N_INPUTS-1:0] idx_r, idx_s;
  logic [N_INPUTS:0]   err_r, err_s;
  logic                ffv_r, ffv_s;
  logic [N_INPUTS-1:0] ffvec_r, ffvec_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                pass_r, pass_s;
  logic                cmp_bit_s;
  logic                mismatch_s;

`ifdef LUT_CHECK_SYNC_EN
  logic [1:0] sync_r;

  // Two-flop synchroniser on the LUT output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], lut_out};
    end
  end

  assign cmp_bit_s = sync_r[1];
`else
  assign cmp_bit_s = lut_out;
`endif

  assign mismatch_s = (cmp_bit_s != TRUTH_TABLE[idx_r]);

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    err_s   = err_r;
    ffv_s   = ffv_r;
    ffvec_s = ffvec_r;
    busy_s  = busy_r;
    done_s  = done_r;
    pass_s  = pass_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_SETTLE;
          cnt_s   = CNT_LOAD;
          idx_s   = IDX_ZERO;
          err_s   = ERR_ZERO;
          ffv_s   = 1'b0;
          ffvec_s = IDX_ZERO;
          busy_s  = 1'b1;
          done_s  = 1'b0;
          pass_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_SAMPLE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_SAMPLE: begin
        if (mismatch_s) begin
          if (err_r != ERR_MAX) begin
            err_s = err_r + ERR_ONE;
          end else begin
            err_s = err_r;
          end
          if (!ffv_r) begin
            ffv_s   = 1'b1;
            ffvec_s = idx_r;
          end else begin
            ffv_s = ffv_r;
          end
        end else begin
          err_s = err_r;
        end
        if (idx_r == LAST_VEC) begin
          // pass uses the count including this final sample.
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (err_s == ERR_ZERO);
        end else begin
          state_s = ST_SETTLE;
          idx_s   = idx_r + IDX_ONE;
          cnt_s   = CNT_LOAD;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
      err_r   <= ERR_ZERO;
      ffv_r   <= 1'b0;
      ffvec_r <= IDX_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      err_r   <= err_s;
      ffv_r   <= ffv_s;
      ffvec_r <= ffvec_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
    end
  end

  assign lut_in           = idx_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign err_count        = err_r;
  assign first_fail_valid = ffv_r;
  assign first_fail_vec   = ffvec_r;

endmodule

// File: tb/tb_lut_truth_table_checker.sv
module tb_lut_truth_table_checker;

`ifdef LUT_CHECK_SYNC_EN
  localparam int HOLD = 11;
  localparam int LAT  = 45;
  localparam int LAT2 = 17;
`else
  localparam int HOLD = 9;
  localparam int LAT  = 37;
  localparam int LAT2 = 9;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] lut_in;
  logic       lut_out;
  logic       dut_f;
  logic       busy, done, pass, ffv;
  logic [2:0] err_count;
  logic [1:0] ffvec;
  logic [1:0] mode;

  logic       start2;
  logic [1:0] lut_in2;
  logic       lut_out2;
  logic       busy2, done2, pass2, ffv2;
  logic [2:0] err2;
  logic [1:0] ffvec2;

  int n_checks = 0;
  int n_errors = 0;
  int vec_cnt [4];
  int order_ok;
  int lat;
  int lat2;

  always #5 clk = ~clk;

  // Model LUTs under test: 0: I0, 1: ~I0, 2: I0|I1, 3: I0&~I1
  always_comb begin
    case (mode)
      2'd0:    dut_f = lut_in[0];
      2'd1:    dut_f = ~lut_in[0];
      2'd2:    dut_f = lut_in[0] | lut_in[1];
      default: dut_f = lut_in[0] & ~lut_in[1];
    endcase
  end

  assign #5 lut_out  = dut_f;
  assign #5 lut_out2 = lut_in2[0];

  lut_truth_table_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lut_in(lut_in), .lut_out(lut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_valid(ffv), .first_fail_vec(ffvec)
  );

  lut_truth_table_checker #(.N_INPUTS(2), .TRUTH_TABLE(4'b1010), .SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .lut_in(lut_in2), .lut_out(lut_out2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then count cycles to done. Optionally re-pulse start at
  // poke_at, or assert reset at rst_at (sweep aborted).
  task automatic sweep(input int poke_at, input int rst_at, output int l);
    int prev;
    for (int i = 0; i < 4; i++) vec_cnt[i] = 0;
    order_ok = 1;
    prev = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    l = 1;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    check("err_cleared", err_count, 0);
    while (done !== 1'b1 && l < 200) begin
      if (int'(lut_in) < prev || int'(lut_in) > prev + 1) order_ok = 0;
      prev = int'(lut_in);
      vec_cnt[lut_in]++;
      start = (l == poke_at);
      if (l == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_lut_in", lut_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_count, 0);
        check("rst_ffv", ffv, 0);
        check("rst_pass", pass, 0);
        break;
      end
      @(negedge clk);
      l++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_lut_in", lut_in, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_err", err_count, 0);
    check("reset_ffv", ffv, 0);
    check("reset_ffvec", ffvec, 0);
    rst_n = 1'b1;

    // O = I0 matches the table
    mode = 2'd0;
    sweep(0, 0, lat);
    check("t1_latency", lat, LAT);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_ffv", ffv, 0);
    check("t1_busy_done", busy, 0);
    check("t1_order", order_ok, 1);
    for (int i = 0; i < 4; i++) check($sformatf("t1_hold_v%0d", i), vec_cnt[i], HOLD);
    repeat (3) @(negedge clk);
    check("t1_done_held", done, 1);
    check("t1_lut_in_last", lut_in, 3);

    // O = ~I0 mismatches everywhere
    mode = 2'd1;
    sweep(0, 0, lat);
    check("t2_latency", lat, LAT);
    check("t2_pass", pass, 0);
    check("t2_err", err_count, 4);
    check("t2_ffv", ffv, 1);
    check("t2_ffvec", ffvec, 0);

    // restart from DONE with a good LUT
    mode = 2'd0;
    sweep(0, 0, lat);
    check("t3_latency", lat, LAT);
    check("t3_pass", pass, 1);
    check("t3_err", err_count, 0);

    // O = I0|I1 mismatches only at vector 2
    mode = 2'd2;
    sweep(0, 0, lat);
    check("t4_err", err_count, 1);
    check("t4_ffvec", ffvec, 2);
    check("t4_pass", pass, 0);

    // O = I0&~I1 mismatches only at the last vector
    mode = 2'd3;
    sweep(0, 0, lat);
    check("t5_err", err_count, 1);
    check("t5_ffvec", ffvec, 3);
    check("t5_ffv", ffv, 1);
    check("t5_pass", pass, 0);

    // start during vector 1 settle is ignored
    mode = 2'd0;
    sweep(HOLD + 3, 0, lat);
    check("t6_latency", lat, LAT);
    check("t6_pass", pass, 1);

    // reset during vector 2, then a clean rerun
    mode = 2'd1;
    sweep(0, 2 * HOLD + 3, lat);
    @(negedge clk); rst_n = 1'b1;
    mode = 2'd0;
    sweep(0, 0, lat);
    check("t7_latency", lat, LAT);
    check("t7_pass", pass, 1);

    // short settle window instance
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    lat2 = 1;
    while (done2 !== 1'b1 && lat2 < 200) begin
      @(negedge clk);
      lat2++;
    end
    check("t8_latency", lat2, LAT2);
    check("t8_pass", pass2, 1);
    check("t8_err", err2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
